// File: rtl/extmem_pkg.sv
// Shared types and constants for the external-memory read prefetcher.
// One line buffer of LINE_WORDS words, tagged by the word address above the line offset.
package extmem_pkg;

   localparam int ADDR_W     = 32;
   localparam int WORD_W     = 32;
   localparam int LINE_WORDS = 4;
   localparam int OFFS_W     = 2;
   localparam int TAG_W      = ADDR_W - OFFS_W;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      MISS_REQ  = 2'd1,
      MISS_FILL = 2'd2,
      RESP      = 2'd3
   } state_t;

   function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] a);
      return {a[ADDR_W-1:OFFS_W], {OFFS_W{1'b0}}};
   endfunction

endpackage

// File: rtl/extmem_if.sv
// DMA read port and external-memory line-fill port of the prefetcher.
// slave is the prefetcher's view; master is the view of its surroundings.
interface extmem_if;
   import extmem_pkg::*;

   logic              r_request_extmem;
   logic [ADDR_W-1:0] addr_extmem;
   logic              r_valid_extmem;
   logic [WORD_W-1:0] data_extmem;
   logic              flush;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic              mem_rvalid;
   logic [WORD_W-1:0] mem_rdata;

   modport slave (
      input  r_request_extmem, addr_extmem, flush, mem_ack, mem_rvalid, mem_rdata,
      output r_valid_extmem, data_extmem, mem_req, mem_addr
   );

   modport master (
      output r_request_extmem, addr_extmem, flush, mem_ack, mem_rvalid, mem_rdata,
      input  r_valid_extmem, data_extmem, mem_req, mem_addr
   );

endinterface

// File: rtl/extmem_line_buf.sv
// Single-line buffer: word storage, tag and valid bit with a combinational hit compare.
// Storage carries no reset; only tag and valid are cleared.
module extmem_line_buf
   import extmem_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [OFFS_W-1:0] wr_idx,
   input  logic [WORD_W-1:0] wr_data,
   input  logic              set_tag,
   input  logic              set_valid,
   input  logic [TAG_W-1:0]  tag_in,
   input  logic              inval,
   input  logic [OFFS_W-1:0] rd_idx,
   output logic [WORD_W-1:0] rd_data,
   input  logic [TAG_W-1:0]  lookup_tag,
   output logic              hit
);

   logic [WORD_W-1:0] line [LINE_WORDS];
   logic [TAG_W-1:0]  tag;
   logic              vld;

   always_ff @(posedge clk) begin
      if (wr_en) line[wr_idx] <= wr_data;
   end

   // Invalidate wins over a tag update so a flush can never be lost.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld <= 1'b0;
         tag <= '0;
      end else if (inval) begin
         vld <= 1'b0;
      end else if (set_tag) begin
         tag <= tag_in;
         vld <= set_valid;
      end
   end

   assign rd_data = line[rd_idx];
   assign hit     = vld && (tag == lookup_tag);

endmodule

// File: rtl/extmem_prefetch.sv
// DMA read front-end that serves word reads from a one-line buffer and
// refills the line with a 4-beat burst from external memory on a miss.
module extmem_prefetch
   import extmem_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   extmem_if.slave          bus,
   output logic [CNT_W-1:0] hit_cnt,
   output logic [CNT_W-1:0] miss_cnt
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   state_t            state;
   logic              r_valid_q;
   logic [WORD_W-1:0] data_q;
   logic              mem_req_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [OFFS_W-1:0] offs_q;
   logic [OFFS_W-1:0] beat;
   logic              flush_pending;

   logic              lb_hit;
   logic [WORD_W-1:0] lb_rd_data;
   logic              lb_wr_en;
   logic              lb_set_tag;
   logic              lb_set_valid;
   logic              lb_inval;
   logic [OFFS_W-1:0] lb_rd_idx;
   logic              is_hit;
   logic              start_miss;

   assign is_hit     = lb_hit && !bus.flush;
   assign start_miss = (state == IDLE) && bus.r_request_extmem && !is_hit;

   // The line is invalidated as soon as a refill starts, so an abandoned fill leaves it invalid.
   always_comb begin
      lb_wr_en     = (state == MISS_FILL) && bus.mem_rvalid;
      lb_set_tag   = lb_wr_en && (beat == OFFS_W'(LINE_WORDS - 1));
      lb_set_valid = !(flush_pending || bus.flush);
      lb_inval     = start_miss ||
                     (bus.flush && ((state == IDLE) || (state == RESP)));
      lb_rd_idx    = (state == IDLE) ? bus.addr_extmem[OFFS_W-1:0] : offs_q;
   end

   extmem_line_buf u_line_buf (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (lb_wr_en),
      .wr_idx     (beat),
      .wr_data    (bus.mem_rdata),
      .set_tag    (lb_set_tag),
      .set_valid  (lb_set_valid),
      .tag_in     (mem_addr_q[ADDR_W-1:OFFS_W]),
      .inval      (lb_inval),
      .rd_idx     (lb_rd_idx),
      .rd_data    (lb_rd_data),
      .lookup_tag (bus.addr_extmem[ADDR_W-1:OFFS_W]),
      .hit        (lb_hit)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         r_valid_q     <= 1'b0;
         data_q        <= '0;
         mem_req_q     <= 1'b0;
         mem_addr_q    <= '0;
         offs_q        <= '0;
         beat          <= '0;
         flush_pending <= 1'b0;
         hit_cnt       <= '0;
         miss_cnt      <= '0;
      end else begin
         r_valid_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.r_request_extmem) begin
                  if (is_hit) begin
                     state     <= RESP;
                     r_valid_q <= 1'b1;
                     data_q    <= lb_rd_data;
                     hit_cnt   <= sat_inc(hit_cnt);
                  end else begin
                     state         <= MISS_REQ;
                     mem_req_q     <= 1'b1;
                     mem_addr_q    <= line_base(bus.addr_extmem);
                     offs_q        <= bus.addr_extmem[OFFS_W-1:0];
                     flush_pending <= 1'b0;
                     miss_cnt      <= sat_inc(miss_cnt);
                  end
               end
            end
            MISS_REQ: begin
               if (bus.flush) flush_pending <= 1'b1;
               if (bus.mem_ack) begin
                  state     <= MISS_FILL;
                  mem_req_q <= 1'b0;
                  beat      <= '0;
               end
            end
            MISS_FILL: begin
               if (bus.flush) flush_pending <= 1'b1;
               if (bus.mem_rvalid) begin
                  beat <= beat + OFFS_W'(1);
                  // Last beat: the requested word may be the one arriving right now.
                  if (beat == OFFS_W'(LINE_WORDS - 1)) begin
                     state         <= RESP;
                     r_valid_q     <= 1'b1;
                     data_q        <= (offs_q == OFFS_W'(LINE_WORDS - 1)) ? bus.mem_rdata
                                                                          : lb_rd_data;
                     flush_pending <= 1'b0;
                  end
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.r_valid_extmem = r_valid_q;
   assign bus.data_extmem    = data_q;
   assign bus.mem_req        = mem_req_q;
   assign bus.mem_addr       = mem_addr_q;

endmodule

// File: tb/tb_extmem_prefetch.sv
// Scoreboard bench for extmem_prefetch: a behavioural burst memory answers fills,
// expected read words are queued at request time and popped on r_valid_extmem.
module tb_extmem_prefetch;
   import extmem_pkg::*;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [CW-1:0] hit_cnt;
   logic [CW-1:0] miss_cnt;

   extmem_if bus ();

   extmem_prefetch #(.CNT_W(CW)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .hit_cnt  (hit_cnt),
      .miss_cnt (miss_cnt)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_mis = 0;
   int          ack_wait = 1;
   bit          stray = 1'b0;
   int          fills = 0;
   int          rvs = 0;
   logic [31:0] cap_addr = '0;
   logic        req_d = 1'b0;
   logic [31:0] exp_q[$];

   int          m_phase = 0;
   int          m_cnt = 0;
   int          m_beat = 0;
   logic [31:0] m_base = '0;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h5A5A_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Fill starts and r_valid pulses, sampled on the active edge.
   always @(posedge clk) begin
      req_d <= bus.mem_req;
      if (bus.mem_req && !req_d) begin
         fills    <= fills + 1;
         cap_addr <= bus.mem_addr;
      end
      if (bus.r_valid_extmem) rvs <= rvs + 1;
   end

   // External memory: ack after ack_wait cycles of mem_req, then 4 back-to-back beats.
   initial begin
      bus.mem_ack    = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;
      forever begin
         @(negedge clk);
         bus.mem_ack    = 1'b0;
         bus.mem_rvalid = 1'b0;
         if (rst) begin
            m_phase = 0;
         end else begin
            case (m_phase)
               0: begin
                  if (bus.mem_req) begin
                     m_base = bus.mem_addr;
                     m_cnt  = 1;
                     if (m_cnt >= ack_wait) begin
                        bus.mem_ack = 1'b1;
                        m_phase     = 2;
                        m_beat      = 0;
                     end else begin
                        m_phase = 1;
                     end
                  end else if (stray) begin
                     bus.mem_ack    = 1'b1;
                     bus.mem_rvalid = 1'b1;
                     bus.mem_rdata  = 32'hDEAD_BEEF;
                  end
               end
               1: begin
                  m_cnt++;
                  if (m_cnt >= ack_wait) begin
                     bus.mem_ack = 1'b1;
                     m_phase     = 2;
                     m_beat      = 0;
                  end
               end
               default: begin
                  bus.mem_rvalid = 1'b1;
                  bus.mem_rdata  = word_of(m_base + 32'(m_beat));
                  m_beat++;
                  if (m_beat == 4) m_phase = 0;
               end
            endcase
         end
      end
   end

   task automatic do_read(input logic [31:0] a, input bit miss, input int aw, input bit hold);
      int          n;
      int          f0;
      int          r0;
      bit          got;
      logic [31:0] exp;
      ack_wait = aw;
      f0 = fills;
      r0 = rvs;
      exp_q.push_back(word_of(a));
      @(negedge clk);
      bus.r_request_extmem = 1'b1;
      bus.addr_extmem      = a;
      n   = 0;
      got = 1'b0;
      while (!got && n < 40) begin
         @(posedge clk);
         #1;
         n++;
         if (bus.r_valid_extmem) got = 1'b1;
      end
      exp = exp_q.pop_front();
      if (!got) begin
         chk("rvalid_timeout", 32'd0, 32'd1);
      end else begin
         chk("read_data", bus.data_extmem, exp);
         chk("latency", 32'(n + 1), miss ? 32'(1 + aw + 4 + 1) : 32'd2);
      end
      if (hold) begin
         @(posedge clk);
         #1;
         chk("rvalid_after_resp", {31'd0, bus.r_valid_extmem}, 32'd0);
      end
      @(negedge clk);
      bus.r_request_extmem = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("fill_count", 32'(fills - f0), miss ? 32'd1 : 32'd0);
      chk("rvalid_pulses", 32'(rvs - r0), 32'd1);
      if (miss) chk("mem_addr", cap_addr, {a[31:2], 2'b00});
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1);
   end

   initial begin
      bus.r_request_extmem = 1'b0;
      bus.addr_extmem      = '0;
      bus.flush            = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rvalid", {31'd0, bus.r_valid_extmem}, 32'd0);
      chk("rst_data", bus.data_extmem, 32'd0);
      chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
      chk("rst_mem_addr", bus.mem_addr, 32'd0);
      chk("rst_hit_cnt", 32'(hit_cnt), 32'd0);
      chk("rst_miss_cnt", 32'(miss_cnt), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Cold miss, then hits on the rest of the line
      do_read(32'h100, 1'b1, 2, 1'b0);
      chk("miss_cnt_cold", 32'(miss_cnt), 32'd1);
      do_read(32'h101, 1'b0, 1, 1'b0);
      do_read(32'h102, 1'b0, 1, 1'b0);
      do_read(32'h103, 1'b0, 1, 1'b0);
      chk("hit_cnt_3", 32'(hit_cnt), 32'd3);

      // Stray ack/rvalid while idle must not disturb the line
      stray = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      stray = 1'b0;
      do_read(32'h100, 1'b0, 1, 1'b0);

      // Offset 3 is served from the beat arriving on the last edge
      do_read(32'h107, 1'b1, 1, 1'b0);
      chk("miss_cnt_2", 32'(miss_cnt), 32'd2);

      // Flush during the fill: data still served, line left invalid
      fork
         do_read(32'h200, 1'b1, 1, 1'b0);
         begin
            repeat (3) @(posedge clk);
            @(negedge clk);
            bus.flush = 1'b1;
            @(negedge clk);
            bus.flush = 1'b0;
         end
      join
      do_read(32'h200, 1'b1, 1, 1'b0);
      do_read(32'h201, 1'b0, 1, 1'b0);

      // Flush while idle
      @(negedge clk);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      do_read(32'h201, 1'b1, 1, 1'b0);

      // Request held through RESP
      do_read(32'h403, 1'b1, 3, 1'b1);
      chk("hit_cnt_5", 32'(hit_cnt), 32'd5);
      chk("miss_cnt_6", 32'(miss_cnt), 32'd6);

      // Hit counter saturation
      for (int i = 0; i < 12; i++) do_read(32'h400 + 32'(i % 4), 1'b0, 1, 1'b0);
      chk("hit_cnt_sat", 32'(hit_cnt), 32'(2 ** CW - 1));
      chk("miss_cnt_kept", 32'(miss_cnt), 32'd6);

      // Asynchronous reset while waiting for the ack
      ack_wait = 6;
      @(negedge clk);
      bus.r_request_extmem = 1'b1;
      bus.addr_extmem      = 32'h300;
      repeat (3) @(posedge clk);
      #1;
      chk("mem_req_before_rst", {31'd0, bus.mem_req}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("mem_req_async_drop", {31'd0, bus.mem_req}, 32'd0);
      chk("rst_hit_clear", 32'(hit_cnt), 32'd0);
      chk("rst_miss_clear", 32'(miss_cnt), 32'd0);
      @(negedge clk);
      bus.r_request_extmem = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      do_read(32'h100, 1'b1, 2, 1'b0);
      do_read(32'h102, 1'b0, 1, 1'b0);
      chk("post_rst_miss_cnt", 32'(miss_cnt), 32'd1);
      chk("post_rst_hit_cnt", 32'(hit_cnt), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
